power_emulator_csr: RTL and testbench

Parametrised, multi-channel register front-end for the power-emulator cores. It sits between the host slave bus and N_CH emulator engines. It turns host writes into one-cycle start pulses and runs a per-channel IDLE/RUN/DONE state machine with cycle counting and timeout. It also captures wide results atomically and raises a maskable interrupt on completion.

---
 rtl/power_emulator_pkg.sv | 34 +++
 rtl/power_emulator_csr_if.sv | 38 +++
 rtl/power_emulator_chan.sv | 151 +++++++++++++++
 rtl/power_emulator_csr.sv | 184 ++++++++++++++++++
 tb/tb_power_emulator_csr.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/power_emulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : power_emulator_pkg
// Description : Shared definitions for the power-emulator register front-end.
//               Holds the register word addresses, the STATUS field offsets
//               and the per-channel state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package power_emulator_pkg;

  // Register word addresses
  localparam logic [2:0] C_ADDR_CTRL      = 3'd0;
  localparam logic [2:0] C_ADDR_STATUS    = 3'd1;
  localparam logic [2:0] C_ADDR_IRQ_EN    = 3'd2;
  localparam logic [2:0] C_ADDR_CH_SEL    = 3'd3;
  localparam logic [2:0] C_ADDR_RESULT_LO = 3'd4;
  localparam logic [2:0] C_ADDR_RESULT_HI = 3'd5;
  localparam logic [2:0] C_ADDR_CYCLES    = 3'd6;
  localparam logic [2:0] C_ADDR_TIMEOUT   = 3'd7;

  // STATUS register field offsets (each field is up to 8 bits wide)
  localparam int C_STATUS_BUSY_OFS    = 0;
  localparam int C_STATUS_DONE_OFS    = 8;
  localparam int C_STATUS_TIMEOUT_OFS = 16;

  // Per-channel state encoding
  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_DONE = 2'd2
  } ch_state_e;

endpackage : power_emulator_pkg
`default_nettype wire

// File: rtl/power_emulator_csr_if.sv
`default_nettype none
// ============================================================================
// Module      : power_emulator_csr_if
// Description : Host slave bus carrying read/write strobes, word address,
//               write data and registered read data.
//   s_read   - read strobe (host -> csr)
//   s_write  - write strobe (host -> csr)
//   s_addr   - word address, ADDR_W bits (host -> csr)
//   s_wdata  - 32-bit write data (host -> csr)
//   s_rdata  - 32-bit registered read data (csr -> host)
// Revision    : 1.0 - initial release
// ============================================================================
interface power_emulator_csr_if #(
  parameter int ADDR_W = 3
);
  logic              s_read;
  logic              s_write;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_wdata;
  logic [31:0]       s_rdata;

  modport master (
    output s_read,
    output s_write,
    output s_addr,
    output s_wdata,
    input  s_rdata
  );

  modport slave (
    input  s_read,
    input  s_write,
    input  s_addr,
    input  s_wdata,
    output s_rdata
  );
endinterface : power_emulator_csr_if
`default_nettype wire

// File: rtl/power_emulator_chan.sv
`default_nettype none
// ============================================================================
// Module      : power_emulator_chan
// Description : One emulator channel: IDLE/RUN/DONE state machine, saturating
//               run-cycle counter with optional timeout, completion flags and
//               atomic capture of the core result and cycle count.
//   clk, reset    - clock, asynchronous active-high reset
//   start_req     - host start request (one cycle)
//   clr_done      - host write-1-to-clear of the done flag
//   clr_timeout   - host write-1-to-clear of the timeout flag
//   timeout_lim   - run limit in cycles, 0 disables
//   core_done     - completion strobe from the core
//   core_result   - result bus from the core
//   start_pulse   - registered one-cycle start pulse to the core
//   busy          - channel is running
//   done_flag     - run completed (normally or by timeout)
//   timeout_flag  - last run ended by timeout
//   result_q      - result captured on normal completion
//   cycles_q      - cycle count of the last run
// Revision    : 1.0 - initial release
// ============================================================================
module power_emulator_chan
  import power_emulator_pkg::*;
#(
  parameter int RES_W = 36,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_req,
  input  logic             clr_done,
  input  logic             clr_timeout,
  input  logic [CNT_W-1:0] timeout_lim,
  input  logic             core_done,
  input  logic [RES_W-1:0] core_result,
  output logic             start_pulse,
  output logic             busy,
  output logic             done_flag,
  output logic             timeout_flag,
  output logic [RES_W-1:0] result_q,
  output logic [CNT_W-1:0] cycles_q
);

  ch_state_e        r_state;
  ch_state_e        w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_limit_hit;
  logic             w_accept_start;
  logic             w_finish_ok;
  logic             w_finish_to;

  // Limit reached when the count including this cycle equals the limit.
  // At saturation the increment wraps to 0, which never matches a non-zero
  // limit, so a saturated counter simply runs on.
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_limit_hit = (timeout_lim != '0) && (w_cnt_inc == timeout_lim);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= CH_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      CH_IDLE, CH_DONE: begin
        if (start_req) begin
          w_next_state = CH_RUN;
        end
      end
      CH_RUN: begin
        // A core completion takes priority over the limit in the same cycle
        if (core_done || w_limit_hit) begin
          w_next_state = CH_DONE;
        end
      end
      default: w_next_state = CH_IDLE;
    endcase
  end

  // Output / event decode
  always_comb begin
    busy           = (r_state == CH_RUN);
    w_accept_start = 1'b0;
    w_finish_ok    = 1'b0;
    w_finish_to    = 1'b0;
    case (r_state)
      CH_IDLE, CH_DONE: w_accept_start = start_req;
      CH_RUN: begin
        w_finish_ok = core_done;
        w_finish_to = !core_done && w_limit_hit;
      end
      default: ;
    endcase
  end

  // Datapath: start pulse, counter, flags and captures
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_pulse  <= 1'b0;
      r_cnt        <= '0;
      done_flag    <= 1'b0;
      timeout_flag <= 1'b0;
      result_q     <= '0;
      cycles_q     <= '0;
    end else begin
      start_pulse <= w_accept_start;

      if (w_accept_start) begin
        r_cnt <= '0;
      end else if (busy && (r_cnt != '1)) begin
        r_cnt <= w_cnt_inc;
      end

      // Start outranks a same-cycle clear; completion outranks a clear too
      if (w_accept_start) begin
        done_flag <= 1'b0;
      end else if (w_finish_ok || w_finish_to) begin
        done_flag <= 1'b1;
      end else if (clr_done) begin
        done_flag <= 1'b0;
      end

      if (w_accept_start) begin
        timeout_flag <= 1'b0;
      end else if (w_finish_to) begin
        timeout_flag <= 1'b1;
      end else if (clr_timeout) begin
        timeout_flag <= 1'b0;
      end

      // Result is only taken from a real completion; a timed-out run leaves
      // the previous result in place
      if (w_finish_ok) begin
        result_q <= core_result;
      end

      if (w_finish_ok || w_finish_to) begin
        cycles_q <= r_cnt;
      end
    end
  end

endmodule : power_emulator_chan
`default_nettype wire

// File: rtl/power_emulator_csr.sv
`default_nettype none
// ============================================================================
// Module      : power_emulator_csr
// Description : Multi-channel register front-end for the power-emulator
//               cores. Decodes host accesses, holds the shared registers,
//               the RESULT_HI snapshot and the interrupt, and instantiates
//               one channel controller per emulator core.
//   clk        - single clock, rising edge
//   reset      - asynchronous active-high reset
//   bus        - host slave bus (read/write/addr/wdata in, rdata out)
//   ch_start   - one-cycle start pulse per channel
//   ch_done    - completion strobe from each core
//   ch_result  - packed core results, channel i at [i*RES_W +: RES_W]
//   irq        - registered interrupt request
// Revision    : 1.0 - initial release
// ============================================================================
module power_emulator_csr
  import power_emulator_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int RES_W  = 36,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  power_emulator_csr_if.slave   bus,
  output logic [N_CH-1:0]       ch_start,
  input  logic [N_CH-1:0]       ch_done,
  input  logic [N_CH*RES_W-1:0] ch_result,
  output logic                  irq
);

  localparam logic [ADDR_W-1:0] C_A_CTRL      = ADDR_W'(C_ADDR_CTRL);
  localparam logic [ADDR_W-1:0] C_A_STATUS    = ADDR_W'(C_ADDR_STATUS);
  localparam logic [ADDR_W-1:0] C_A_IRQ_EN    = ADDR_W'(C_ADDR_IRQ_EN);
  localparam logic [ADDR_W-1:0] C_A_CH_SEL    = ADDR_W'(C_ADDR_CH_SEL);
  localparam logic [ADDR_W-1:0] C_A_RESULT_LO = ADDR_W'(C_ADDR_RESULT_LO);
  localparam logic [ADDR_W-1:0] C_A_RESULT_HI = ADDR_W'(C_ADDR_RESULT_HI);
  localparam logic [ADDR_W-1:0] C_A_CYCLES    = ADDR_W'(C_ADDR_CYCLES);
  localparam logic [ADDR_W-1:0] C_A_TIMEOUT   = ADDR_W'(C_ADDR_TIMEOUT);

  // Shared registers
  logic [N_CH-1:0]  r_irq_en;
  logic [2:0]       r_ch_sel;
  logic [CNT_W-1:0] r_timeout;
  logic [31:0]      r_hi_snap;

  // Per-channel control and status
  logic [N_CH-1:0]            w_start_req;
  logic [N_CH-1:0]            w_clr_done;
  logic [N_CH-1:0]            w_clr_to;
  logic [N_CH-1:0]            w_busy;
  logic [N_CH-1:0]            w_done;
  logic [N_CH-1:0]            w_to;
  logic [N_CH-1:0][RES_W-1:0] w_res;
  logic [N_CH-1:0][CNT_W-1:0] w_cyc;

  // Selected-channel view
  logic [RES_W-1:0] w_sel_res;
  logic [CNT_W-1:0] w_sel_cyc;
  logic [63:0]      w_sel_res64;

  logic        w_wr_ctrl;
  logic        w_wr_status;
  logic        w_rd_lo;
  logic [31:0] w_rd_mux;
  logic        unused_wdata;

  // Not every write-data bit lands in a register for every parameter set
  assign unused_wdata = ^bus.s_wdata;

  assign w_wr_ctrl   = bus.s_write && (bus.s_addr == C_A_CTRL);
  assign w_wr_status = bus.s_write && (bus.s_addr == C_A_STATUS);
  assign w_rd_lo     = bus.s_read  && (bus.s_addr == C_A_RESULT_LO);

  // Host-side strobes per channel: CTRL bit i starts, STATUS W1C clears
  always_comb begin
    w_start_req = '0;
    w_clr_done  = '0;
    w_clr_to    = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_start_req[i] = w_wr_ctrl   && bus.s_wdata[i];
      w_clr_done[i]  = w_wr_status && bus.s_wdata[C_STATUS_DONE_OFS + i];
      w_clr_to[i]    = w_wr_status && bus.s_wdata[C_STATUS_TIMEOUT_OFS + i];
    end
  end

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_chan
      power_emulator_chan #(
        .RES_W (RES_W),
        .CNT_W (CNT_W)
      ) u_chan (
        .clk          (clk),
        .reset        (reset),
        .start_req    (w_start_req[g]),
        .clr_done     (w_clr_done[g]),
        .clr_timeout  (w_clr_to[g]),
        .timeout_lim  (r_timeout),
        .core_done    (ch_done[g]),
        .core_result  (ch_result[g*RES_W +: RES_W]),
        .start_pulse  (ch_start[g]),
        .busy         (w_busy[g]),
        .done_flag    (w_done[g]),
        .timeout_flag (w_to[g]),
        .result_q     (w_res[g]),
        .cycles_q     (w_cyc[g])
      );
    end
  endgenerate

  // Channel select mux; a select beyond the channel count matches nothing
  // and therefore reads as zero
  always_comb begin
    w_sel_res = '0;
    w_sel_cyc = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_ch_sel == 3'(i)) begin
        w_sel_res = w_res[i];
        w_sel_cyc = w_cyc[i];
      end
    end
  end

  assign w_sel_res64 = 64'(w_sel_res);

  // Read mux over the current (pre-write) register contents
  always_comb begin
    w_rd_mux = '0;
    case (bus.s_addr)
      C_A_CTRL: w_rd_mux = '0;
      C_A_STATUS: begin
        for (int i = 0; i < N_CH; i++) begin
          w_rd_mux[C_STATUS_BUSY_OFS + i]    = w_busy[i];
          w_rd_mux[C_STATUS_DONE_OFS + i]    = w_done[i];
          w_rd_mux[C_STATUS_TIMEOUT_OFS + i] = w_to[i];
        end
      end
      C_A_IRQ_EN:    w_rd_mux = 32'(r_irq_en);
      C_A_CH_SEL:    w_rd_mux = 32'(r_ch_sel);
      C_A_RESULT_LO: w_rd_mux = w_sel_res64[31:0];
      C_A_RESULT_HI: w_rd_mux = r_hi_snap;
      C_A_CYCLES:    w_rd_mux = 32'(w_sel_cyc);
      C_A_TIMEOUT:   w_rd_mux = 32'(r_timeout);
      default:       w_rd_mux = '0;
    endcase
  end

  // Shared registers, read data, HI snapshot and interrupt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_en    <= '0;
      r_ch_sel    <= '0;
      r_timeout   <= '0;
      r_hi_snap   <= '0;
      bus.s_rdata <= '0;
      irq         <= 1'b0;
    end else begin
      if (bus.s_write) begin
        case (bus.s_addr)
          C_A_IRQ_EN:  r_irq_en  <= bus.s_wdata[N_CH-1:0];
          C_A_CH_SEL:  r_ch_sel  <= bus.s_wdata[2:0];
          C_A_TIMEOUT: r_timeout <= bus.s_wdata[CNT_W-1:0];
          default: ;
        endcase
      end

      if (bus.s_read) begin
        bus.s_rdata <= w_rd_mux;
      end

      // Upper result word is frozen together with the LO read so a
      // LO-then-HI sequence always returns one consistent result
      if (w_rd_lo) begin
        r_hi_snap <= w_sel_res64[63:32];
      end

      irq <= |(w_done & r_irq_en);
    end
  end

endmodule : power_emulator_csr
`default_nettype wire

// File: tb/tb_power_emulator_csr.sv
`default_nettype none
// ============================================================================
// Module      : tb_power_emulator_csr
// Description : Directed self-checking bench for power_emulator_csr with
//               hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_power_emulator_csr;

  localparam int N_CH   = 4;
  localparam int RES_W  = 36;
  localparam int CNT_W  = 32;
  localparam int ADDR_W = 3;

  logic                  clk;
  logic                  reset;
  logic [N_CH-1:0]       ch_start;
  logic [N_CH-1:0]       ch_done;
  logic [N_CH*RES_W-1:0] ch_result;
  logic                  irq;

  int n_tests;
  int n_fail;

  power_emulator_csr_if #(.ADDR_W(ADDR_W)) bus ();

  power_emulator_csr #(
    .N_CH   (N_CH),
    .RES_W  (RES_W),
    .CNT_W  (CNT_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .ch_start  (ch_start),
    .ch_done   (ch_done),
    .ch_result (ch_result),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.s_write = 1'b1;
    bus.s_addr  = a;
    bus.s_wdata = d;
    tick();
    bus.s_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus.s_read = 1'b1;
    bus.s_addr = a;
    tick();
    bus.s_read = 1'b0;
    d = bus.s_rdata;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a,
                            input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check_value(tag, 64'(d), 64'(exp));
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b1;
    bus.s_read  = 1'b0;
    bus.s_write = 1'b0;
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    ch_done     = '0;
    ch_result   = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // ---- Reset state: every address reads 0, irq low
    for (int a = 0; a < 8; a++) begin
      read_check($sformatf("reset_rd_%0d", a), 3'(a), 32'h0);
    end
    check_value("reset_irq", 64'(irq), 64'h0);

    // ---- Channel 0 normal run, ch_done in the 11th cycle -> CYCLES 10
    ch_result[0*RES_W +: RES_W] = 36'hA_1234_5678;
    bus_write(3'd0, 32'h1);
    check_value("ch0_start_pulse", 64'(ch_start), 64'h1);
    read_check("ch0_busy", 3'd1, 32'h1);
    check_value("ch0_start_once", 64'(ch_start), 64'h0);
    repeat (9) tick();
    ch_done[0] = 1'b1;
    tick();
    ch_done[0] = 1'b0;
    read_check("ch0_status", 3'd1, 32'h100);
    bus_write(3'd3, 32'h0);
    read_check("ch0_res_lo", 3'd4, 32'h1234_5678);
    read_check("ch0_res_hi", 3'd5, 32'hA);
    read_check("ch0_cycles", 3'd6, 32'd10);

    // ---- Channel 1 timeout after 5 cycles, result retained
    bus_write(3'd7, 32'd5);
    ch_result[1*RES_W +: RES_W] = 36'h5_DEAD_BEEF;
    bus_write(3'd0, 32'h2);
    repeat (4) tick();
    read_check("ch1_still_busy", 3'd1, 32'h102);
    read_check("ch1_timeout_status", 3'd1, 32'h2_0300);
    bus_write(3'd3, 32'h1);
    read_check("ch1_res_kept_lo", 3'd4, 32'h0);
    read_check("ch1_res_kept_hi", 3'd5, 32'h0);

    // ---- Channel 2 with interrupt enabled
    bus_write(3'd2, 32'h4);
    bus_write(3'd7, 32'd0);
    bus_write(3'd0, 32'h4);
    ch_result[2*RES_W +: RES_W] = 36'h0_0000_00FF;
    repeat (2) tick();
    ch_done[2] = 1'b1;
    tick();
    ch_done[2] = 1'b0;
    check_value("irq_not_yet", 64'(irq), 64'h0);
    tick();
    check_value("irq_rise", 64'(irq), 64'h1);
    bus_write(3'd1, 32'h400);
    tick();
    check_value("irq_fall", 64'(irq), 64'h0);
    read_check("ch2_cleared_status", 3'd1, 32'h2_0300);
    bus_write(3'd3, 32'h2);
    read_check("ch2_cycles", 3'd6, 32'd2);

    // ---- Channel 0: restart while running ignored; done coincides with limit
    bus_write(3'd7, 32'd6);
    bus_write(3'd0, 32'h1);
    check_value("ch0b_start_pulse", 64'(ch_start), 64'h1);
    tick();
    bus_write(3'd0, 32'h1);
    check_value("ch0b_no_restart", 64'(ch_start), 64'h0);
    repeat (3) tick();
    ch_result[0*RES_W +: RES_W] = 36'h3_0000_0042;
    ch_done[0] = 1'b1;
    tick();
    ch_done[0] = 1'b0;
    read_check("ch0b_status", 3'd1, 32'h2_0300);
    bus_write(3'd3, 32'h0);
    read_check("ch0b_cycles", 3'd6, 32'd5);
    read_check("ch0b_res_lo", 3'd4, 32'h42);
    read_check("ch0b_res_hi", 3'd5, 32'h3);

    // ---- Reset during a run; later ch_done is ignored
    bus_write(3'd7, 32'd0);
    bus_write(3'd1, 32'h00FF_FF00);
    bus_write(3'd0, 32'h1);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check_value("rst_ch_start", 64'(ch_start), 64'h0);
    reset = 1'b0;
    bus_write(3'd2, 32'h1);
    ch_done[0] = 1'b1;
    tick();
    ch_done[0] = 1'b0;
    repeat (2) tick();
    check_value("rst_irq", 64'(irq), 64'h0);
    read_check("rst_status", 3'd1, 32'h0);
    read_check("rst_cycles", 3'd6, 32'h0);

    // ---- Same-address read and write: read returns the old value
    bus.s_read  = 1'b1;
    bus.s_write = 1'b1;
    bus.s_addr  = 3'd2;
    bus.s_wdata = 32'hFF;
    tick();
    bus.s_read  = 1'b0;
    bus.s_write = 1'b0;
    check_value("rw_same_old", 64'(bus.s_rdata), 64'h1);
    // Bits above N_CH are dropped
    read_check("irq_en_masked", 3'd2, 32'hF);
    tick();
    check_value("rdata_hold", 64'(bus.s_rdata), 64'hF);
    // CH_SEL beyond the channel count reads zero
    bus_write(3'd3, 32'h5);
    read_check("ch_sel_read", 3'd3, 32'h5);
    read_check("ch_sel_oob_cycles", 3'd6, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_power_emulator_csr
`default_nettype wire
